// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit Wishbone master.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size_e'(size))
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = MASK_D;
    endcase
  endfunction

endpackage

// File: rtl/lsu_wb_align.sv
// Byte-lane steering: WRITE=1 shifts data up to its lane, WRITE=0 shifts the
// addressed lane down and sign- or zero-extends it to the full bus width.
module lsu_wb_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit WRITE  = 1'b0
) (
  input  logic [1:0]                     size,
  input  logic                           is_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]    offset,
  input  logic [DATA_W-1:0]              data_in,
  output logic [DATA_W-1:0]              data_out
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] extended;
  logic              sign_bit;

  always_comb begin
    if (WRITE) begin
      shifted = data_in << {offset, 3'b000};
    end else begin
      shifted = data_in >> {offset, 3'b000};
    end

    sign_bit  = 1'b0;
    lane_mask = '1;
    case (size_e'(size))
      SZ_B: begin
        sign_bit  = ~is_unsigned & shifted[7];
        lane_mask = DATA_W'(8'hFF);
      end
      SZ_H: begin
        sign_bit  = ~is_unsigned & shifted[15];
        lane_mask = DATA_W'(16'hFFFF);
      end
      SZ_W: begin
        sign_bit  = ~is_unsigned & shifted[31];
        lane_mask = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        sign_bit  = 1'b0;
        lane_mask = '1;
      end
    endcase

    extended = (shifted & lane_mask) | ({DATA_W{sign_bit}} & ~lane_mask);
    data_out = WRITE ? shifted : extended;
  end

endmodule

// File: rtl/lsu_wb_master.sv
// Single-outstanding LSU to Wishbone B4 pipelined master, all outputs registered.
// Optional bus-cycle timeout is enabled by defining LSU_WB_TIMEOUT_EN.
module lsu_wb_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_stall_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);

  state_e              state_reg, state_next;
  logic                req_ready_reg, req_ready_next;
  logic                resp_valid_reg, resp_valid_next;
  logic                resp_err_reg, resp_err_next;
  logic [DATA_W-1:0]   resp_rdata_reg, resp_rdata_next;
  logic                cyc_reg, cyc_next;
  logic                stb_reg, stb_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   adr_reg, adr_next;
  logic [DATA_W-1:0]   dat_reg, dat_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [1:0]          size_reg, size_next;
  logic                uns_reg, uns_next;
  logic [OFF_W-1:0]    off_reg, off_next;

  logic                misaligned;
  logic                illegal;
  logic [7:0]          sel_full;
  logic [DATA_W-1:0]   wr_lane;
  logic [DATA_W-1:0]   rd_lane;
  logic                tmo_hit;

  lsu_wb_align #(.DATA_W(DATA_W), .WRITE(1'b1)) u_align_wr (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .offset      (req_addr[OFF_W-1:0]),
    .data_in     (req_wdata),
    .data_out    (wr_lane)
  );

  lsu_wb_align #(.DATA_W(DATA_W), .WRITE(1'b0)) u_align_rd (
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .offset      (off_reg),
    .data_in     (wb_dat_i),
    .data_out    (rd_lane)
  );

  always_comb begin
    case (size_e'(req_size))
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
    illegal  = misaligned || ((req_size == SZ_D) && (DATA_W == 32));
    sel_full = size_mask(req_size) << req_addr[OFF_W-1:0];
  end

`ifdef LSU_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE && state_next == ST_REQ) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Counter holds k-1 during the k-th bus cycle, so this fires on the last allowed one.
  assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    cyc_next        = cyc_reg;
    stb_next        = stb_reg;
    we_next         = we_reg;
    adr_next        = adr_reg;
    dat_next        = dat_reg;
    sel_next        = sel_reg;
    size_next       = size_reg;
    uns_next        = uns_reg;
    off_next        = off_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = '0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          size_next = req_size;
          uns_next  = req_unsigned;
          off_next  = req_addr[OFF_W-1:0];
          if (illegal) begin
            state_next      = ST_RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            state_next = ST_REQ;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
            we_next    = req_we;
            adr_next   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            dat_next   = wr_lane;
            sel_next   = sel_full[SEL_W-1:0];
          end
        end
      end
      ST_REQ: begin
        if (tmo_hit) begin
          state_next      = ST_RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
        end else if (!wb_stall_i) begin
          state_next = ST_WAIT;
          stb_next   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wb_err_i || tmo_hit) begin
          state_next      = ST_RESP;
          resp_valid_next = 1'b1;
          resp_err_next   = 1'b1;
        end else if (wb_ack_i) begin
          state_next      = ST_RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = we_reg ? '0 : rd_lane;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Any transition into RESP from a bus cycle releases the bus entirely.
    if (state_next == ST_RESP && state_reg != ST_IDLE) begin
      cyc_next = 1'b0;
      stb_next = 1'b0;
      we_next  = 1'b0;
      adr_next = '0;
      dat_next = '0;
      sel_next = '0;
    end

    req_ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      cyc_reg        <= 1'b0;
      stb_reg        <= 1'b0;
      we_reg         <= 1'b0;
      adr_reg        <= '0;
      dat_reg        <= '0;
      sel_reg        <= '0;
      size_reg       <= '0;
      uns_reg        <= 1'b0;
      off_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      cyc_reg        <= cyc_next;
      stb_reg        <= stb_next;
      we_reg         <= we_next;
      adr_reg        <= adr_next;
      dat_reg        <= dat_next;
      sel_reg        <= sel_next;
      size_reg       <= size_next;
      uns_reg        <= uns_next;
      off_reg        <= off_next;
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign wb_cyc_o   = cyc_reg;
  assign wb_stb_o   = stb_reg;
  assign wb_we_o    = we_reg;
  assign wb_adr_o   = adr_reg;
  assign wb_dat_o   = dat_reg;
  assign wb_sel_o   = sel_reg;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Scoreboard bench for lsu_wb_master (DATA_W=32); adapts to LSU_WB_TIMEOUT_EN.
module tb_lsu_wb_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic              clk;
  logic              rst_n;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [3:0]        wb_sel_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i, wb_err_i, wb_stall_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  lsu_wb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_resp", resp_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("resp: err=%0d rdata=0x%08h (exp err=%0d rdata=0x%08h)",
                 resp_err, resp_rdata, e.err, e.rdata);
        check("resp_err", resp_err, e.err);
        check("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("ready_before_req", req_ready, 1'b1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // term: 0 = ack, 1 = err, 2 = ack and err together
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stalls, input logic ack_in_req, input int term,
                         input logic [31:0] bus_rdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input logic [3:0] exp_sel,
                         input logic [31:0] exp_dat, input logic [31:0] exp_adr);
    exp_t e;
    drive_req(we, sz, uns, addr, wdata);
    e.err = exp_err;
    e.rdata = exp_rdata;
    sb_q.push_back(e);
    wb_stall_i = (stalls > 0);
    wb_ack_i   = ack_in_req;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i <= stalls; i++) begin
      @(negedge clk);
      check("req_cyc", wb_cyc_o, 1'b1);
      check("req_stb", wb_stb_o, 1'b1);
      check("req_we", wb_we_o, we);
      check("req_adr", wb_adr_o, exp_adr);
      check("req_sel", wb_sel_o, exp_sel);
      check("req_dat", wb_dat_o, exp_dat);
      check("req_no_resp", resp_valid, 1'b0);
      wb_stall_i = (i < stalls);
      if (i == stalls) wb_ack_i = 1'b0;
    end
    @(negedge clk);
    check("wait_stb", wb_stb_o, 1'b0);
    check("wait_cyc", wb_cyc_o, 1'b1);
    wb_dat_i = bus_rdata;
    wb_ack_i = (term != 1);
    wb_err_i = (term != 0);
    @(posedge clk);
    #1;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    @(negedge clk);
    check("resp_latency", resp_valid, 1'b1);
    check("resp_cyc_low", wb_cyc_o, 1'b0);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
    check("ready_after_resp", req_ready, 1'b1);
  endtask

  task automatic run_illegal(input logic [1:0] sz, input logic [31:0] addr);
    exp_t e;
    drive_req(1'b0, sz, 1'b0, addr, 32'h0);
    e.err = 1'b1;
    e.rdata = 32'h0;
    sb_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("ill_resp_latency", resp_valid, 1'b1);
    check("ill_no_cyc", wb_cyc_o, 1'b0);
    @(negedge clk);
    check("ill_no_cyc2", wb_cyc_o, 1'b0);
    check("ill_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; wb_dat_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_sel", wb_sel_o, 4'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    rst_n = 1'b1;

    // SB 0x103
    run_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'hAB, 0, 1'b0, 0, 32'h0,
            1'b0, 32'h0, 4'b1000, 32'hAB00_0000, 32'h100);
    // LH / LHU 0x102
    run_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 1'b0, 0, 32'h8001_1234,
            1'b0, 32'hFFFF_8001, 4'b1100, 32'h0, 32'h100);
    run_txn(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 1'b0, 0, 32'h8001_1234,
            1'b0, 32'h0000_8001, 4'b1100, 32'h0, 32'h100);
    // LW misaligned, LD on a 32-bit bus
    run_illegal(2'b10, 32'h101);
    run_illegal(2'b11, 32'h208);
    // LB signed lane 1, LBU lane 3, LW aligned
    run_txn(1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 0, 1'b0, 0, 32'h1234_8056,
            1'b0, 32'hFFFF_FF80, 4'b0010, 32'h0, 32'h000);
    run_txn(1'b0, 2'b00, 1'b1, 32'h003, 32'h0, 0, 1'b0, 0, 32'hFF00_0000,
            1'b0, 32'h0000_00FF, 4'b1000, 32'h0, 32'h000);
    run_txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 1'b0, 0, 32'hDEAD_BEEF,
            1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h300);
    // SW stalled 4 cycles with ack raised in REQ, then ack+err together
    run_txn(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678, 4, 1'b1, 2, 32'h0,
            1'b1, 32'h0, 4'b1111, 32'h1234_5678, 32'h200);
    // LW terminated by err; SH upper half
    run_txn(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 0, 1'b0, 1, 32'hFFFF_FFFF,
            1'b1, 32'h0, 4'b1111, 32'h0, 32'h204);
    run_txn(1'b1, 2'b01, 1'b0, 32'h206, 32'hBEEF, 1, 1'b0, 0, 32'h0,
            1'b0, 32'h0, 4'b1100, 32'hBEEF_0000, 32'h204);

    // Read that is never terminated
    begin
      exp_t e;
      drive_req(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
`ifdef LSU_WB_TIMEOUT_EN
      e.err = 1'b1;
      e.rdata = 32'h0;
      sb_q.push_back(e);
`endif
      @(posedge clk);
      #1 req_valid = 1'b0;
      cnt = 0;
`ifdef LSU_WB_TIMEOUT_EN
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!wb_cyc_o) break;
        cnt++;
      end
      check("tmo_cyc_cycles", cnt, TMO);
      check("tmo_resp_valid", resp_valid, 1'b1);
      @(negedge clk);
`else
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (wb_cyc_o) cnt++;
      end
      check("no_tmo_cyc_cycles", cnt, 1000);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
`endif
      check("ready_after_hang", req_ready, 1'b1);
    end

    // Reset while in WAIT, then a late ack must be ignored
    drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_cyc", wb_cyc_o, 1'b1);
    check("rstw_stb", wb_stb_o, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstw_cyc_drop", wb_cyc_o, 1'b0);
    check("rstw_stb_drop", wb_stb_o, 1'b0);
    rst_n = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_no_resp", resp_valid, 1'b0);
    end
    wb_ack_i = 1'b0;
    check("rstw_ready", req_ready, 1'b1);
    check("rstw_cyc_idle", wb_cyc_o, 1'b0);

    @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
